data_mem_be: RTL
================

DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 4..65536.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  1  access request, sampled on clk while ready=1.
REQ-007 we  in  1  1=store, 0=load.
REQ-008 addr  in  ADDR_WIDTH  byte address.
REQ-009 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 sign_ext  in  1  loads: 1=sign-extend, 0=zero-extend.
REQ-011 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 ready  out  1  block accepts requests.
REQ-013 rvalid  out  1  one-cycle pulse: load data valid, or error response.
REQ-014 rdata  out  32  extended load data.
REQ-015 err  out  1  valid with rvalid; misaligned or reserved-size access.

Function
REQ-016 SHALL index word = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap).
REQ-017 SHALL accept a request only on a clk edge with req=1 and ready=1; otherwise ignored, no response.
REQ-018 SHALL treat as error: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
REQ-019 SHALL, for an error, leave memory unmodified and drive rvalid=1, err=1, rdata=0 one cycle after acceptance.
REQ-020 SHALL, for an aligned store, write only the addressed lanes at the accepting edge (byte: lane addr[1:0]; half: lanes 2*addr[1]..+1; word: all 4); no rvalid.
REQ-021 SHALL, for an aligned load, return data with rvalid=1, err=0 exactly one cycle after acceptance (latency 1).
REQ-022 SHALL select lanes for loads as for stores, shift to bit 0, and extend to 32 bits per sign_ext (ignored for word).
REQ-023 SHALL support back-to-back requests every cycle; a load following a store to the same word SHALL return the new data.
REQ-024 SHALL hold rdata at its last value when rvalid=0; err SHALL be 0 when rvalid=0.
REQ-025 SHALL implement states CLEAR and RUN: CLEAR -> RUN when clear counter reaches DEPTH_WORDS-1; RUN is terminal until reset.
REQ-026 SHALL in CLEAR write 0 to word counter per cycle, counter 0..DEPTH_WORDS-1, ready=0.
REQ-027 SHALL drive ready=1 only in RUN.

Reset
REQ-028 SHALL on rst_n=0 set ready=0, rvalid=0, err=0, rdata=0, counter=0, state per REQ-031/032, regardless of clk.
REQ-029 SHALL abandon any in-flight load on reset; no rvalid after rst_n release until a new load is accepted.
REQ-030 SHALL not reset memory contents asynchronously.

Configuration
REQ-031 With DMEM_INIT_CLEAR_EN defined: reset enters CLEAR; ready rises DEPTH_WORDS cycles after rst_n release; all words read 0.
REQ-032 Without DMEM_INIT_CLEAR_EN: reset enters RUN; ready=1 at first edge after release; contents undefined until written; no clear counter.

Verification
REQ-033 Clear: DMEM_INIT_CLEAR_EN, DEPTH_WORDS=256, release rst_n -> ready=0 for 256 cycles then 1; word load at 0x3FC -> rdata=0x00000000.
REQ-034 Lanes: word store 0x11223344 @0x30, byte store 0xAA @0x31, then word load @0x30 -> rdata=0x1122AA44 next cycle, err=0.
REQ-035 Extension: store 0x0000F080 @0x40; byte load @0x40 sign_ext=1 -> 0xFFFFFF80; half load @0x40 sign_ext=0 -> 0x0000F080.
REQ-036 Errors: word load @0x32 -> rvalid=1, err=1, rdata=0; half store @0x41 -> err=1 and word @0x40 unchanged; size=11 -> err=1.
REQ-037 Wrap/back-to-back: DEPTH_WORDS=256, store 0xDEADBEEF @0x400 then load @0x000 next cycle -> 0xDEADBEEF.
REQ-038 Reset mid-op: load accepted, rst_n low before next edge -> rvalid stays 0; after release ready follows REQ-031/032.

Source files
------------

// File: rtl/data_mem_be_if.sv
// Request/response bus of data_mem_be: one request per cycle while ready is high;
// loads and errors answer with a single-cycle rvalid pulse.
interface data_mem_be_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [31:0]           wdata;
  logic                  ready;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic                  err;

  modport master (
    output req, we, addr, size, sign_ext, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, size, sign_ext, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_be.sv
// Byte-enabled 32-bit data memory with sign/zero-extending loads and latency-1 responses.
// Define DMEM_INIT_CLEAR_EN to zero every word after reset before accepting requests.
module data_mem_be #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_be_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  logic [31:0]     mem [DEPTH_WORDS];
  state_e          state_q;
  logic            ready_q;
  logic            rvalid_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [IdxW-1:0] idx;
  logic [1:0]      lane;
  logic            accept;
  logic            bad;
  logic [3:0]      mem_be;
  logic [IdxW-1:0] mem_idx;
  logic [31:0]     mem_wdata;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_data;
  logic            unused_addr;

`ifdef DMEM_INIT_CLEAR_EN
  logic [IdxW-1:0] clr_cnt_q;
`endif

  // Upper address bits alias onto the same words.
  assign idx         = bus.addr[IdxW+1:2];
  assign lane        = bus.addr[1:0];
  assign unused_addr = ^bus.addr;
  assign accept      = bus.req & ready_q;

  always_comb begin
    unique case (bus.size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = |lane;
      default: bad = 1'b1;
    endcase
  end

  // Store lanes: replicate the right-aligned data so every enabled lane sees its byte.
  always_comb begin
    mem_idx   = idx;
    mem_be    = 4'b0000;
    mem_wdata = bus.wdata;
    unique case (bus.size)
      2'b00: begin
        mem_be    = 4'b0001 << lane;
        mem_wdata = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = lane[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{bus.wdata[15:0]}};
      end
      default: mem_be = 4'b1111;
    endcase
    if (!(accept && bus.we && !bad)) begin
      mem_be = 4'b0000;
    end
`ifdef DMEM_INIT_CLEAR_EN
    if (state_q == StClear) begin
      mem_idx   = clr_cnt_q;
      mem_be    = 4'b1111;
      mem_wdata = '0;
    end
`endif
  end

  always_comb begin
    word      = mem[idx];
    byte_v    = word[{lane, 3'b000} +: 8];
    half_v    = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    unique case (bus.size)
      2'b00:   load_data = {{24{bus.sign_ext & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{bus.sign_ext & half_v[15]}}, half_v};
      default: load_data = word;
    endcase
  end

  // Contents survive reset; only the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
      state_q   <= StClear;
      clr_cnt_q <= '0;
`else
      state_q   <= StRun;
`endif
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        StClear: begin
`ifdef DMEM_INIT_CLEAR_EN
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == IdxW'(DEPTH_WORDS - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
`else
          state_q <= StRun;
`endif
        end
        default: begin
          ready_q <= 1'b1;
          if (accept && (bad || !bus.we)) begin
            rvalid_q <= 1'b1;
            err_q    <= bad;
            rdata_q  <= bad ? 32'h0 : load_data;
          end
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

endmodule
